// File: rtl/time_keeper_ctrl.sv
// Hours/minutes timekeeper with RUN / SET_HOUR / SET_MIN mode FSM, field blink and
// day rollover strobe. All outputs are registered.
module time_keeper_ctrl #(
  parameter int unsigned INIT_HOUR = 0,
  parameter int unsigned INIT_MIN  = 0,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       min_tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_pulse
);

  localparam int unsigned CntW = $clog2(BLINK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StSetHour = 2'b01,
    StSetMin  = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      hours_q, hours_d;
  logic [5:0]      minutes_q, minutes_d;
  logic            blink_q, blink_d;
  logic            day_q, day_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    blink_d   = blink_q;
    cnt_d     = cnt_q;
    day_d     = 1'b0;

    unique case (state_q)
      StRun: begin
        // A tick coincident with btn_mode is still applied before leaving RUN.
        if (min_tick) begin
          if (minutes_q == 6'd59) begin
            minutes_d = '0;
            if (hours_q == 5'd23) begin
              hours_d = '0;
              day_d   = 1'b1;
            end else begin
              hours_d = hours_q + 5'd1;
            end
          end else begin
            minutes_d = minutes_q + 6'd1;
          end
        end
        if (btn_mode) state_d = StSetHour;
      end
      StSetHour: begin
        if (btn_mode) begin
          state_d = StSetMin;
        end else if (btn_up) begin
          hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
        end
      end
      StSetMin: begin
        if (btn_mode) begin
          state_d = StRun;
        end else if (btn_up) begin
          minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
        end
      end
      default: state_d = StRun;
    endcase

    // Blink restarts high on entry to a set state and whenever the field is bumped.
    if (state_d != state_q) begin
      cnt_d   = '0;
      blink_d = (state_d != StRun);
    end else if (state_q == StRun) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (btn_up) begin
      cnt_d   = '0;
      blink_d = 1'b1;
    end else if (cnt_q == CntMax) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      hours_q   <= 5'(INIT_HOUR);
      minutes_q <= 6'(INIT_MIN);
      blink_q   <= 1'b0;
      day_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      blink_q   <= blink_d;
      day_q     <= day_d;
      cnt_q     <= cnt_d;
    end
  end

  assign hours     = hours_q;
  assign minutes   = minutes_q;
  assign mode      = state_q;
  assign blink     = blink_q;
  assign day_pulse = day_q;

endmodule

// File: tb/tb_time_keeper_ctrl.sv
// Scoreboard bench for time_keeper_ctrl: expected output records are queued as each
// stimulus cycle is driven and compared once the DUT has registered its response.
module tb_time_keeper_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       min_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [1:0] mode;
  logic       blink;
  logic       day_pulse;

  logic [14:0] obs;
  logic [14:0] sb[$];
  int          tests = 0;
  int          fails = 0;

  time_keeper_ctrl #(
    .INIT_HOUR(23),
    .INIT_MIN (58),
    .BLINK_DIV(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .min_tick (min_tick),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .hours    (hours),
    .minutes  (minutes),
    .mode     (mode),
    .blink    (blink),
    .day_pulse(day_pulse)
  );

  always #5 clk = ~clk;

  assign obs = {hours, minutes, mode, blink, day_pulse};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  function automatic logic [14:0] rec(input int h, input int mi, input int md,
                                      input logic b, input logic d);
    return {5'(h), 6'(mi), 2'(md), b, d};
  endfunction

  // Stimulus step: {min_tick, btn_mode, btn_up, expected record}.
  function automatic logic [17:0] st(input logic t, input logic m, input logic u,
                                     input logic [14:0] e);
    return {t, m, u, e};
  endfunction

  function automatic string fmt(input logic [14:0] v);
    return $sformatf("%0d:%0d mode=%0d blink=%b day=%b", v[14:10], v[9:4], v[3:2], v[1], v[0]);
  endfunction

  task automatic cyc(input logic t, input logic m, input logic u);
    min_tick = t;
    btn_mode = m;
    btn_up   = u;
    @(posedge clk);
    #1;
    min_tick = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] e;
    rst_n    = 1'b0;
    min_tick = 1'b1;
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    #12;
    e = rec(23, 58, 0, 1'b0, 1'b0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_hold: got %s, expected %s", fmt(obs), fmt(e));
    end
    @(negedge clk);
    min_tick = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    rst_n    = 1'b1;
    #1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_release: got %s, expected %s", fmt(obs), fmt(e));
    end
  endtask

  task automatic test_rollover;
    logic [17:0] steps[$];
    logic [14:0] e;
    steps.push_back(st(1, 0, 0, rec(23, 59, 0, 0, 0)));
    steps.push_back(st(1, 0, 0, rec(0, 0, 0, 0, 1)));
    steps.push_back(st(0, 0, 0, rec(0, 0, 0, 0, 0)));
    steps.push_back(st(0, 0, 1, rec(0, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      sb.push_back(steps[i][14:0]);
      cyc(steps[i][17], steps[i][16], steps[i][15]);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL rollover[%0d]: got %s, expected %s", i, fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_mode_walk;
    logic [17:0] steps[$];
    logic [14:0] e;
    steps.push_back(st(0, 1, 0, rec(0, 0, 1, 1, 0)));
    for (int i = 1; i <= 5; i++) steps.push_back(st(0, 0, 1, rec(i, 0, 1, 1, 0)));
    steps.push_back(st(0, 1, 0, rec(5, 0, 2, 1, 0)));
    for (int i = 1; i <= 61; i++) steps.push_back(st(0, 0, 1, rec(5, i % 60, 2, 1, 0)));
    steps.push_back(st(0, 1, 0, rec(5, 1, 0, 0, 0)));
    foreach (steps[i]) begin
      sb.push_back(steps[i][14:0]);
      cyc(steps[i][17], steps[i][16], steps[i][15]);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL mode_walk[%0d]: got %s, expected %s", i, fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_run_carry;
    logic [17:0] steps[$];
    logic [14:0] e;
    steps.push_back(st(0, 1, 0, rec(5, 1, 1, 1, 0)));
    for (int i = 6; i <= 10; i++) steps.push_back(st(0, 0, 1, rec(i, 1, 1, 1, 0)));
    steps.push_back(st(0, 1, 0, rec(10, 1, 2, 1, 0)));
    for (int i = 2; i <= 59; i++) steps.push_back(st(0, 0, 1, rec(10, i, 2, 1, 0)));
    steps.push_back(st(0, 1, 0, rec(10, 59, 0, 0, 0)));
    steps.push_back(st(1, 0, 0, rec(11, 0, 0, 0, 0)));
    steps.push_back(st(0, 0, 1, rec(11, 0, 0, 0, 0)));
    steps.push_back(st(0, 0, 0, rec(11, 0, 0, 0, 0)));
    foreach (steps[i]) begin
      sb.push_back(steps[i][14:0]);
      cyc(steps[i][17], steps[i][16], steps[i][15]);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL run_carry[%0d]: got %s, expected %s", i, fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_set_freeze;
    logic [17:0] steps[$];
    logic [14:0] e;
    steps.push_back(st(0, 1, 0, rec(11, 0, 1, 1, 0)));
    steps.push_back(st(0, 1, 0, rec(11, 0, 2, 1, 0)));
    for (int i = 0; i < 3; i++) steps.push_back(st(1, 0, 0, rec(11, 0, 2, 1, 0)));
    steps.push_back(st(0, 1, 0, rec(11, 0, 0, 0, 0)));
    steps.push_back(st(1, 0, 0, rec(11, 1, 0, 0, 0)));
    // Tick and mode together in RUN, then mode and up together in the set states.
    steps.push_back(st(1, 1, 0, rec(11, 2, 1, 1, 0)));
    steps.push_back(st(0, 1, 1, rec(11, 2, 2, 1, 0)));
    steps.push_back(st(0, 1, 1, rec(11, 2, 0, 0, 0)));
    foreach (steps[i]) begin
      sb.push_back(steps[i][14:0]);
      cyc(steps[i][17], steps[i][16], steps[i][15]);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL set_freeze[%0d]: got %s, expected %s", i, fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_blink;
    logic [17:0] steps[$];
    logic [14:0] e;
    steps.push_back(st(0, 1, 0, rec(11, 2, 1, 1, 0)));
    for (int i = 0; i < 3; i++) steps.push_back(st(0, 0, 0, rec(11, 2, 1, 1, 0)));
    for (int i = 0; i < 4; i++) steps.push_back(st(0, 0, 0, rec(11, 2, 1, 0, 0)));
    for (int i = 0; i < 4; i++) steps.push_back(st(0, 0, 0, rec(11, 2, 1, 1, 0)));
    for (int i = 0; i < 2; i++) steps.push_back(st(0, 0, 0, rec(11, 2, 1, 0, 0)));
    steps.push_back(st(0, 0, 1, rec(12, 2, 1, 1, 0)));
    for (int i = 0; i < 3; i++) steps.push_back(st(0, 0, 0, rec(12, 2, 1, 1, 0)));
    steps.push_back(st(0, 0, 0, rec(12, 2, 1, 0, 0)));
    steps.push_back(st(0, 1, 0, rec(12, 2, 2, 1, 0)));
    for (int i = 0; i < 3; i++) steps.push_back(st(0, 0, 0, rec(12, 2, 2, 1, 0)));
    steps.push_back(st(0, 0, 0, rec(12, 2, 2, 0, 0)));
    steps.push_back(st(0, 1, 0, rec(12, 2, 0, 0, 0)));
    for (int i = 0; i < 5; i++) steps.push_back(st(0, 0, 0, rec(12, 2, 0, 0, 0)));
    foreach (steps[i]) begin
      sb.push_back(steps[i][14:0]);
      cyc(steps[i][17], steps[i][16], steps[i][15]);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL blink[%0d]: got %s, expected %s", i, fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [17:0] steps[$];
    logic [17:0] after[$];
    logic [14:0] e;
    steps.push_back(st(0, 1, 0, rec(12, 2, 1, 1, 0)));
    for (int i = 1; i <= 19; i++) steps.push_back(st(0, 0, 1, rec((12 + i) % 24, 2, 1, 1, 0)));
    steps.push_back(st(0, 1, 0, rec(7, 2, 2, 1, 0)));
    for (int i = 3; i <= 33; i++) steps.push_back(st(0, 0, 1, rec(7, i, 2, 1, 0)));
    for (int i = 0; i < 2; i++) steps.push_back(st(0, 0, 0, rec(7, 33, 2, 1, 0)));
    foreach (steps[i]) begin
      sb.push_back(steps[i][14:0]);
      cyc(steps[i][17], steps[i][16], steps[i][15]);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_mid_setup[%0d]: got %s, expected %s", i, fmt(obs), fmt(e));
      end
    end
    // Asynchronous reset between edges, with strobes held through the next edge.
    #2;
    rst_n    = 1'b0;
    min_tick = 1'b1;
    btn_up   = 1'b1;
    #1;
    e = rec(23, 58, 0, 1'b0, 1'b0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_mid_async: got %s, expected %s", fmt(obs), fmt(e));
    end
    @(posedge clk);
    #1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_mid_held: got %s, expected %s", fmt(obs), fmt(e));
    end
    #2;
    rst_n    = 1'b1;
    min_tick = 1'b0;
    btn_up   = 1'b0;
    after.push_back(st(0, 1, 1, rec(23, 58, 1, 1, 0)));
    after.push_back(st(0, 0, 0, rec(23, 58, 1, 1, 0)));
    foreach (after[i]) begin
      sb.push_back(after[i][14:0]);
      cyc(after[i][17], after[i][16], after[i][15]);
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_mid_after[%0d]: got %s, expected %s", i, fmt(obs), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset;
    test_rollover;
    test_mode_walk;
    test_run_carry;
    test_set_freeze;
    test_blink;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/time_keeper_ctrl.md
TIME_KEEPER_CTRL -- requirements
Module: time_keeper_ctrl

Interface
REQ-001 Parameter INIT_HOUR, default 0: hours value loaded at reset, range 0..23.
REQ-002 Parameter INIT_MIN, default 0: minutes value loaded at reset, range 0..59.
REQ-003 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period, >=2.
REQ-004 Port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port min_tick  input  1  one-cycle strobe per elapsed minute from the minute generator, synchronous to clk.
REQ-007 Port btn_mode  input  1  debounced one-cycle pulse; advances the mode.
REQ-008 Port btn_up  input  1  debounced one-cycle pulse; increments the field being set.
REQ-009 Port hours  output  5  current hours, binary, 0..23.
REQ-010 Port minutes  output  6  current minutes, binary, 0..59.
REQ-011 Port mode  output  2  FSM state: 00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven.
REQ-012 Port blink  output  1  display blink enable for the field being set.
REQ-013 Port day_pulse  output  1  one-cycle strobe on 23:59 -> 00:00 rollover.

Function
REQ-014 All outputs SHALL be registered; every response appears on the cycle after the triggering strobe is sampled.
REQ-015 FSM SHALL have states RUN, SET_HOUR, SET_MIN; btn_mode moves RUN->SET_HOUR->SET_MIN->RUN, one step per pulse.
REQ-016 Illegal state encoding 11 SHALL return to RUN on the next clk edge without altering hours/minutes.
REQ-017 In RUN, min_tick SHALL increment minutes; minutes 59 wraps to 0 and increments hours in the same cycle.
REQ-018 In RUN, hours 23 with carry SHALL wrap to 0; a 23:59 tick yields 00:00 and day_pulse=1 for exactly one cycle.
REQ-019 In RUN, btn_up SHALL be ignored.
REQ-020 In SET_HOUR, btn_up SHALL increment hours modulo 24; minutes unchanged.
REQ-021 In SET_MIN, btn_up SHALL increment minutes modulo 60 with no carry into hours and no day_pulse.
REQ-022 In SET_HOUR and SET_MIN, min_tick SHALL be discarded (time frozen; missed ticks not accumulated).
REQ-023 btn_mode and btn_up in the same cycle: mode transition taken, btn_up ignored.
REQ-024 btn_mode and min_tick in the same cycle while in RUN: tick applied and transition to SET_HOUR taken in that same cycle.
REQ-025 Blink counter SHALL count clk cycles only in SET_HOUR/SET_MIN, toggling blink after every BLINK_DIV cycles; blink starts at 1.
REQ-026 On every mode transition the blink counter SHALL clear and blink SHALL be 1 in set states, 0 in RUN.
REQ-027 btn_up in a set state SHALL clear the blink counter and force blink=1 so the new value is visible.
REQ-028 day_pulse SHALL be 0 in every cycle other than the one defined in REQ-018.

Reset
REQ-029 While rst_n=0: mode=00, hours=INIT_HOUR, minutes=INIT_MIN, blink=0, day_pulse=0, blink counter=0, independent of clk.
REQ-030 Reset asserted mid-operation (any state, mid-blink, coincident with strobes) SHALL discard all pending activity; strobes in the first clk edge after release are processed normally.

Verification
REQ-031 Reset with INIT 23:58, two min_tick pulses -> 23:59, then 00:00 with day_pulse high for exactly one cycle.
REQ-032 RUN at 10:59, min_tick -> 11:00, day_pulse stays 0; btn_up in RUN -> no change.
REQ-033 btn_mode, 5x btn_up, btn_mode, 61x btn_up, btn_mode from 00:00 -> mode 01,01..,10,..,00; final time 05:01, no day_pulse.
REQ-034 In SET_MIN, 3 min_tick pulses, then btn_mode -> minutes unchanged, mode 00, subsequent tick increments by 1 only.
REQ-035 BLINK_DIV=4 in SET_HOUR -> blink 1 for 4 cycles, 0 for 4 cycles; btn_up mid-low-phase -> blink 1 next cycle, count restarts.
REQ-036 rst_n pulsed low between clk edges while in SET_MIN at 07:33 -> immediate mode 00, INIT time, blink 0; btn_mode+btn_up same cycle afterwards -> mode 01, hours unchanged.
